// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-register pipeline: merges stage stall requests
// with MEM-stage exceptions and delays the exception redirect until the buses drain.
module pipe_ctrl #(
    parameter int DRAIN_TO = 255,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_sreq,
    input  logic             id_sreq,
    input  logic             ex_sreq,
    input  logic             mem_sreq,
    input  logic             excp_req,
    input  logic [31:0]      excp_tgt,
    input  logic             ibus_busy,
    input  logic             dbus_busy,
    input  logic             cnt_clr,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic             redirect,
    output logic [31:0]      flush_pc,
    output logic             bus_abort,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        REDIR = 2'd2
    } state_t;

    localparam int DW = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TO - 1);

    state_t         state_q;
    state_t         state_d;
    logic [DW-1:0]  drain_q;
    logic [DW-1:0]  drain_d;
    logic [31:0]    tgt_q;
    logic [31:0]    tgt_d;
    logic           busy;

    assign busy      = ibus_busy | dbus_busy;
    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        tgt_d     = tgt_q;
        stall     = 5'b00000;
        flush     = 5'b00000;
        redirect  = 1'b0;
        flush_pc  = tgt_q;
        bus_abort = 1'b0;

        case (state_q)
            RUN: begin
                if (excp_req) begin
                    if (!busy) begin
                        flush    = 5'b11111;
                        redirect = 1'b1;
                        flush_pc = excp_tgt;
                    end else begin
                        // Freeze everything and remember where to go once the buses are quiet
                        stall   = 5'b11111;
                        tgt_d   = excp_tgt;
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end else if (mem_sreq) begin
                    stall = 5'b01111;
                    flush = 5'b10000;
                end else if (ex_sreq) begin
                    stall = 5'b00111;
                    flush = 5'b01000;
                end else if (id_sreq) begin
                    stall = 5'b00011;
                    flush = 5'b00100;
                end else if (if_sreq) begin
                    stall = 5'b00001;
                    flush = 5'b00010;
                end
            end
            DRAIN: begin
                stall = 5'b11111;
                if (!busy) begin
                    state_d = REDIR;
                end else if (drain_q == DRAIN_LAST) begin
                    bus_abort = 1'b1;
                    state_d   = REDIR;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            REDIR: begin
                flush    = 5'b11111;
                redirect = 1'b1;
                state_d  = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Outputs go quiet the instant reset asserts, not at the next edge
        if (rst) begin
            stall     = 5'b00000;
            flush     = 5'b00000;
            redirect  = 1'b0;
            flush_pc  = 32'h0;
            bus_abort = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            drain_q   <= '0;
            tgt_q     <= 32'h0;
            stall_cnt <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            tgt_q   <= tgt_d;
            if (cnt_clr) begin
                stall_cnt <= '0;
            end else if (stall[0] && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule
